// File: rtl/fpu_result_stage.sv
// fpu_result_stage: DEPTH-entry result FIFO after the FP add/sub datapath. It tags each entry with an IEEE class code when the entry is pushed.
// Latency: an entry pushed at edge N is visible at the head after edge N. There is no bypass path.
// Backpressure: in_ready depends only on registered state, never on out_ready. Optional macro: FPU_STICKY_FLAGS_EN (accumulated status flags).
module fpu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_error,
    input  logic        in_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_class,
    output logic        out_error,
    output logic        out_overflow,
    input  logic        sticky_clr,
    output logic [1:0]  sticky_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  cls;
        logic        error;
        logic        overflow;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            live;
    logic            push;
    logic            pop;
    entry_t          head;

    // Class code of a single-precision word; sign is not part of the class.
    function automatic logic [2:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] f;
        e = v[30:23];
        f = v[22:0];
        if (e == 8'h00)       classify = (f == '0) ? 3'b000 : 3'b001;
        else if (e != 8'hFF)  classify = 3'b010;
        else if (f == '0)     classify = 3'b011;
        else if (f[22])       classify = 3'b100;
        else                  classify = 3'b101;
    endfunction

    // Handshakes: ready comes only from registers, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = live && (count < FULL_COUNT);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Ready is held low until the first clock edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) live <= 1'b0;
        else       live <= 1'b1;
    end

    // Occupancy and pointers. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage. Empty slots are never presented, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{result:   in_result,
                             cls:      classify(in_result),
                             error:    in_error,
                             overflow: in_overflow};
        end
    end

    // Head presentation. Outputs read zero whenever the stage is empty, and that includes reset.
    always_comb begin
        head         = mem[rd_ptr];
        out_result   = out_valid ? head.result   : 32'h0;
        out_class    = out_valid ? head.cls      : 3'b000;
        out_error    = out_valid && head.error;
        out_overflow = out_valid && head.overflow;
    end

`ifdef FPU_STICKY_FLAGS_EN
    logic [1:0] sticky_q;

    // Accumulate popped flags. A set in the same cycle as a clear takes priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sticky_q <= 2'b00;
        else       sticky_q <= (sticky_clr ? 2'b00 : sticky_q)
                             | (pop ? {out_overflow, out_error} : 2'b00);
    end

    assign sticky_flags = sticky_q;
`else
    // The feature is compiled out: the ports stay, the status is constant and the clear input has no effect.
    logic sticky_clr_unused;
    assign sticky_clr_unused = sticky_clr;
    assign sticky_flags      = 2'b00;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
module tb_fpu_result_stage;

    localparam int DEPTH = 2;
`ifdef FPU_STICKY_FLAGS_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_class;
    logic        out_error;
    logic        out_overflow;
    logic        sticky_clr;
    logic [1:0]  sticky_flags;

    fpu_result_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_error(in_error), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_class(out_class), .out_error(out_error), .out_overflow(out_overflow),
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of accepted entries and the accumulated status.
    typedef struct {
        logic [31:0] r;
        logic        e;
        logic        o;
    } ent_t;

    ent_t       mq[$];
    bit         m_live;
    logic [1:0] m_sticky;
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference class rules, written as plain integer arithmetic on exponent and fraction.
    function automatic logic [2:0] ref_class(input logic [31:0] v);
        int e;
        int f;
        e = int'(v[30:23]);
        f = int'(v[22:0]);
        if (e == 0)            return (f == 0) ? 3'd0 : 3'd1;
        if (e != 255)          return 3'd2;
        if (f == 0)            return 3'd3;
        if (f >= (1 << 22))    return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = r[30:23];
        endcase
        case ($urandom_range(0, 3))
            0:       f = '0;
            1:       f = {1'b1, r[21:0]};
            2:       f = {1'b0, r[21:1], 1'b1};
            default: f = r[22:0];
        endcase
        return {r[31], e, f};
    endfunction

    // Advance one clock edge and update the model using the inputs held across that edge.
    task automatic cycle();
        bit         push;
        bit         pop;
        logic [1:0] s;
        ent_t       n;
        push = !reset && in_valid && m_live && (mq.size() < DEPTH);
        pop  = !reset && out_ready && (mq.size() > 0);
        if (!reset && STICKY_ON) begin
            s = sticky_clr ? 2'b00 : m_sticky;
            if (pop) s = s | {mq[0].o, mq[0].e};
            m_sticky = s;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            n.r = in_result; n.e = in_error; n.o = in_overflow;
            mq.push_back(n);
        end
        @(posedge clk);
        #1;
        if (!reset) m_live = 1'b1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        repeat (DEPTH + 1) cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_result = 32'h3F800000;
        in_error = 1'b1; in_overflow = 1'b1; out_ready = 1'b1; sticky_clr = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        cycle(); cycle();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_hold got v=%b r=%b want 0 0", out_valid, in_ready); else n_pass++;
        n_checks++; if (out_result !== 32'h0 || out_class !== 3'b000) $display("FAIL reset_data got %h/%b want 0/000", out_result, out_class); else n_pass++;
        n_checks++; if (out_error !== 1'b0 || out_overflow !== 1'b0 || sticky_flags !== 2'b00)
            $display("FAIL reset_flags got e=%b o=%b s=%b want 0 0 00", out_error, out_overflow, sticky_flags); else n_pass++;
        in_valid = 1'b0;
        reset = 1'b0;
        cycle();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_passthrough();
        in_valid = 1'b1; in_result = 32'h3F800000; in_error = 1'b0; in_overflow = 1'b0; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 32'h3F800000) $display("FAIL pass_result got %h want 3f800000", out_result); else n_pass++;
        n_checks++; if (out_class !== 3'b010) $display("FAIL pass_class got %b want 010", out_class); else n_pass++;
        n_checks++; if (out_error !== 1'b0 || out_overflow !== 1'b0) $display("FAIL pass_flags got %b%b want 00", out_error, out_overflow); else n_pass++;
        drain();
    endtask

    task automatic test_classes();
        logic [31:0] vals [5];
        logic [2:0]  cls  [5];
        vals = '{32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001};
        cls  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
        in_error = 1'b0; in_overflow = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_result = vals[i];
            cycle();
            n_checks++;
            if (out_class !== cls[i] || out_result !== vals[i])
                $display("FAIL class_%0d got %b/%h want %b/%h", i, out_class, out_result, cls[i], vals[i]);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] v [3];
        for (int i = 0; i < 3; i++) v[i] = $urandom;
        out_ready = 1'b0; in_error = 1'b0; in_overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_result = v[i];
            if (i == 2) begin
                n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else n_pass++;
            end
            cycle();
        end
        in_valid = 1'b0;
        n_checks++; if (out_result !== v[0] || out_valid !== 1'b1) $display("FAIL bp_head got %h v=%b want %h", out_result, out_valid, v[0]); else n_pass++;
        out_ready = 1'b1;
        cycle();
        n_checks++; if (out_result !== v[1] || out_valid !== 1'b1) $display("FAIL bp_second got %h v=%b want %h", out_result, out_valid, v[1]); else n_pass++;
        cycle();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_third_dropped got valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [9];
        for (int i = 0; i < 9; i++) v[i] = rand_fp();
        in_error = 1'b0; in_overflow = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_result = v[0];
        cycle();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_result = v[k];
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== v[k-1])
                $display("FAIL b2b_%0d got r=%b v=%b %h want 1 1 %h", k, in_ready, out_valid, out_result, v[k-1]);
            else n_pass++;
            cycle();
        end
        in_valid = 1'b0;
        n_checks++; if (out_result !== v[8] || out_valid !== 1'b1) $display("FAIL b2b_last got %h want %h", out_result, v[8]); else n_pass++;
        drain();
    endtask

    task automatic test_sticky();
        logic [1:0] want;
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        in_valid = 1'b1; in_result = 32'h7F800000; in_error = 1'b1; in_overflow = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        want = STICKY_ON ? 2'b11 : 2'b00;
        n_checks++; if (sticky_flags !== want) $display("FAIL sticky_set got %b want %b", sticky_flags, want); else n_pass++;
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        n_checks++; if (sticky_flags !== 2'b00) $display("FAIL sticky_clear got %b want 00", sticky_flags); else n_pass++;
        out_ready = 1'b0; in_valid = 1'b1; in_error = 1'b1; in_overflow = 1'b0; in_result = 32'h7FC00000;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        want = STICKY_ON ? 2'b01 : 2'b00;
        n_checks++; if (sticky_flags !== want) $display("FAIL sticky_clr_vs_set got %b want %b", sticky_flags, want); else n_pass++;
        drain();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0); in_result = rand_fp();
            in_error = $urandom; in_overflow = $urandom;
            out_ready = ($urandom_range(0, 2) != 0); sticky_clr = ($urandom_range(0, 7) == 0);
            #1;
            n_checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH) || sticky_flags !== m_sticky) begin
                errs++;
                if (errs < 10) $display("FAIL rand_ctrl_%0d got v=%b r=%b s=%b want v=%0d r=%0d s=%b",
                                        i, out_valid, in_ready, sticky_flags, mq.size() > 0, mq.size() < DEPTH, m_sticky);
            end else if (mq.size() > 0 && (out_result !== mq[0].r || out_class !== ref_class(mq[0].r)
                                           || out_error !== mq[0].e || out_overflow !== mq[0].o)) begin
                errs++;
                if (errs < 10) $display("FAIL rand_head_%0d got %h/%b/%b%b want %h/%b/%b%b", i, out_result, out_class,
                                        out_error, out_overflow, mq[0].r, ref_class(mq[0].r), mq[0].e, mq[0].o);
            end else n_pass++;
            cycle();
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_error = 1'b0; in_overflow = 1'b0;
        in_valid = 1'b1; in_result = 32'h40000000; cycle();
        in_result = 32'h40400000; cycle();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL areset_pre got v=%b r=%b want 1 0", out_valid, in_ready); else n_pass++;
        #3 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'h0)
            $display("FAIL areset_immediate got v=%b r=%b %h want 0 0 0", out_valid, in_ready, out_result); else n_pass++;
        mq.delete(); m_live = 1'b0; m_sticky = 2'b00;
        @(posedge clk); #1;
        cycle();
        reset = 1'b0; out_ready = 1'b1;
        cycle();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL areset_after got v=%b r=%b want 0 1", out_valid, in_ready); else n_pass++;
    endtask

    initial begin
        m_live = 1'b0; m_sticky = 2'b00;
        test_reset();
        test_passthrough();
        test_classes();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
